regfile_sb: RTL and testbench

- Parametrised successor to the core's single-write register file: NREG x XLEN storage with two combinational read ports and two write-back ports.
- Same-cycle write-to-read forwarding.
- Integrated scoreboard: busy bits per register with an issue valid/ready handshake, used by the pipeline to stall on RAW/WAW hazards against multi-cycle producers (loads, mul/div).
- Register 0 is hard-wired to zero.

---
 rtl/regfile_pkg.sv | 19 +
 rtl/regfile_scoreboard.sv | 78 +++++++
 rtl/regfile_sb.sv | 104 ++++++++++
 tb/tb_regfile_sb.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// ============================================================================
// Module      : regfile_pkg
// Description : Shared sizing constants and typedefs for the regfile_sb block.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package regfile_pkg;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int AW   = $clog2(NREG);

    typedef logic [AW-1:0]   reg_addr_t;
    typedef logic [XLEN-1:0] xword_t;

endpackage : regfile_pkg

`default_nettype wire

// File: rtl/regfile_scoreboard.sv
// ============================================================================
// Module      : regfile_scoreboard
// Description : Per-register busy bits with RAW/WAW issue gating.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter  int NREG = regfile_pkg::NREG,
    localparam int AW   = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_we0,
    input  logic [AW-1:0] i_wa0,
    input  logic          i_we1,
    input  logic [AW-1:0] i_wa1,
    input  logic          i_iss_valid,
    input  logic [AW-1:0] i_iss_rs1,
    input  logic [AW-1:0] i_iss_rs2,
    input  logic [AW-1:0] i_iss_rd,
    output logic          o_iss_ready,
    output logic          o_busy_any
);

    logic [NREG-1:0] r_busy_q;
    logic [NREG-1:0] w_busy_d;
    logic            w_hazard;

    // A write-back landing this cycle satisfies the hazard through the bypass.
    function automatic logic src_busy(
        input logic [NREG-1:0] busy,
        input logic [AW-1:0]   a,
        input logic            we0,
        input logic [AW-1:0]   wa0,
        input logic            we1,
        input logic [AW-1:0]   wa1
    );
        return (a != '0) && busy[a] && !(we0 && (wa0 == a)) && !(we1 && (wa1 == a));
    endfunction

    always_comb begin
        w_hazard = src_busy(r_busy_q, i_iss_rs1, i_we0, i_wa0, i_we1, i_wa1)
                 | src_busy(r_busy_q, i_iss_rs2, i_we0, i_wa0, i_we1, i_wa1)
                 | src_busy(r_busy_q, i_iss_rd,  i_we0, i_wa0, i_we1, i_wa1);
    end

    assign o_iss_ready = !w_hazard;
    assign o_busy_any  = |r_busy_q;

    // Clears first, then the accepted issue, so a new producer wins the tie.
    always_comb begin
        w_busy_d = r_busy_q;
        if (i_we0 && (i_wa0 != '0)) begin
            w_busy_d[i_wa0] = 1'b0;
        end
        if (i_we1 && (i_wa1 != '0)) begin
            w_busy_d[i_wa1] = 1'b0;
        end
        if (i_iss_valid && o_iss_ready && (i_iss_rd != '0)) begin
            w_busy_d[i_iss_rd] = 1'b1;
        end
        w_busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy_q <= '0;
        end else begin
            r_busy_q <= w_busy_d;
        end
    end

endmodule : regfile_scoreboard

`default_nettype wire

// File: rtl/regfile_sb.sv
// ============================================================================
// Module      : regfile_sb
// Description : NREG x XLEN register file, 2R/2W with bypass and scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_sb
    import regfile_pkg::*;
#(
    parameter  int XLEN = regfile_pkg::XLEN,
    parameter  int NREG = regfile_pkg::NREG,
    localparam int AW   = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   ra1,
    input  logic [AW-1:0]   ra2,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2,
    input  logic            we0,
    input  logic [AW-1:0]   wa0,
    input  logic [XLEN-1:0] wd0,
    input  logic            we1,
    input  logic [AW-1:0]   wa1,
    input  logic [XLEN-1:0] wd1,
    input  logic            iss_valid,
    input  logic [AW-1:0]   iss_rs1,
    input  logic [AW-1:0]   iss_rs2,
    input  logic [AW-1:0]   iss_rd,
    output logic            iss_ready,
    output logic            busy_any
);

    logic [XLEN-1:0] r_mem_q [NREG];
    logic [XLEN-1:0] w_mem_d [NREG];

    function automatic logic [XLEN-1:0] read_port(
        input logic [AW-1:0]   ra,
        input logic [XLEN-1:0] stored,
        input logic            we0_f,
        input logic [AW-1:0]   wa0_f,
        input logic [XLEN-1:0] wd0_f,
        input logic            we1_f,
        input logic [AW-1:0]   wa1_f,
        input logic [XLEN-1:0] wd1_f
    );
        if (ra == '0) begin
            return '0;
        end else if (we1_f && (wa1_f == ra)) begin
            return wd1_f;
        end else if (we0_f && (wa0_f == ra)) begin
            return wd0_f;
        end
        return stored;
    endfunction

    always_comb begin
        rd1 = read_port(ra1, r_mem_q[ra1], we0, wa0, wd0, we1, wa1, wd1);
        rd2 = read_port(ra2, r_mem_q[ra2], we0, wa0, wd0, we1, wa1, wd1);
    end

    // Port 1 is applied last so it overrides port 0 on an address collision.
    always_comb begin
        w_mem_d = r_mem_q;
        if (we0 && (wa0 != '0)) begin
            w_mem_d[wa0] = wd0;
        end
        if (we1 && (wa1 != '0)) begin
            w_mem_d[wa1] = wd1;
        end
        w_mem_d[0] = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                r_mem_q[i] <= '0;
            end
        end else begin
            r_mem_q <= w_mem_d;
        end
    end

    regfile_scoreboard #(
        .NREG (NREG)
    ) u_scoreboard (
        .clk         (clk),
        .rst         (rst),
        .i_we0       (we0),
        .i_wa0       (wa0),
        .i_we1       (we1),
        .i_wa1       (wa1),
        .i_iss_valid (iss_valid),
        .i_iss_rs1   (iss_rs1),
        .i_iss_rs2   (iss_rs2),
        .i_iss_rd    (iss_rd),
        .o_iss_ready (iss_ready),
        .o_busy_any  (busy_any)
    );

endmodule : regfile_sb

`default_nettype wire

// File: tb/tb_regfile_sb.sv
// ============================================================================
// Module      : tb_regfile_sb
// Description : Directed vector table plus scoreboard sequences for regfile_sb.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile_sb;
    import regfile_pkg::*;

    logic      clk;
    logic      rst;
    reg_addr_t ra1, ra2, wa0, wa1, iss_rs1, iss_rs2, iss_rd;
    xword_t    rd1, rd2, wd0, wd1;
    logic      we0, we1, iss_valid, iss_ready, busy_any;

    int errors;
    int checks;

    typedef struct {
        reg_addr_t ra1;
        reg_addr_t ra2;
        logic      we0;
        reg_addr_t wa0;
        xword_t    wd0;
        logic      we1;
        reg_addr_t wa1;
        xword_t    wd1;
        xword_t    exp_rd1;
        xword_t    exp_rd2;
    } vec_t;

    vec_t vecs [10];

    regfile_sb dut (
        .clk       (clk),
        .rst       (rst),
        .ra1       (ra1),
        .ra2       (ra2),
        .rd1       (rd1),
        .rd2       (rd2),
        .we0       (we0),
        .wa0       (wa0),
        .wd0       (wd0),
        .we1       (we1),
        .wa1       (wa1),
        .wd1       (wd1),
        .iss_valid (iss_valid),
        .iss_rs1   (iss_rs1),
        .iss_rs2   (iss_rs2),
        .iss_rd    (iss_rd),
        .iss_ready (iss_ready),
        .busy_any  (busy_any)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        we0 = 0; wa0 = '0; wd0 = '0;
        we1 = 0; wa1 = '0; wd1 = '0;
        iss_valid = 0; iss_rs1 = '0; iss_rs2 = '0; iss_rd = '0;
    endtask

    task automatic issue(input reg_addr_t rs1, input reg_addr_t rs2, input reg_addr_t rd);
        iss_valid = 1; iss_rs1 = rs1; iss_rs2 = rs2; iss_rd = rd;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst = 1;
        ra1 = '0; ra2 = '0;
        clear_inputs();

        vecs[0] = '{5'd3,  5'd3,  1, 5'd3,  32'h11,   1, 5'd3,  32'h22,       32'h22,       32'h22};
        vecs[1] = '{5'd3,  5'd0,  0, 5'd0,  32'h0,    0, 5'd0,  32'h0,        32'h22,       32'h0};
        vecs[2] = '{5'd0,  5'd0,  0, 5'd0,  32'h0,    1, 5'd0,  32'h55,       32'h0,        32'h0};
        vecs[3] = '{5'd10, 5'd11, 1, 5'd10, 32'hA5A5, 1, 5'd11, 32'h5A5A,     32'hA5A5,     32'h5A5A};
        vecs[4] = '{5'd10, 5'd11, 0, 5'd0,  32'h0,    0, 5'd0,  32'h0,        32'hA5A5,     32'h5A5A};
        vecs[5] = '{5'd10, 5'd11, 1, 5'd10, 32'h1234, 0, 5'd0,  32'h0,        32'h1234,     32'h5A5A};
        vecs[6] = '{5'd0,  5'd10, 1, 5'd0,  32'hFFFF, 0, 5'd0,  32'h0,        32'h0,        32'h1234};
        vecs[7] = '{5'd31, 5'd1,  0, 5'd0,  32'h0,    0, 5'd0,  32'h0,        32'h0,        32'h0};
        vecs[8] = '{5'd31, 5'd1,  1, 5'd1,  32'h1,    1, 5'd31, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1};
        vecs[9] = '{5'd31, 5'd1,  0, 5'd0,  32'h0,    0, 5'd0,  32'h0,        32'hFFFFFFFF, 32'h1};

        tick();
        // Write presented together with reset must be dropped.
        we0 = 1; wa0 = 5'd5; wd0 = 32'hDEADBEEF;
        tick();
        rst = 0;
        clear_inputs();
        #1;
        for (int i = 0; i < NREG; i++) begin
            ra1 = reg_addr_t'(i);
            ra2 = reg_addr_t'(NREG - 1 - i);
            #1;
            check($sformatf("reset_rd1[%0d]", i), rd1, 32'h0);
            check($sformatf("reset_rd2[%0d]", NREG - 1 - i), rd2, 32'h0);
        end
        check("reset_busy_any", {31'b0, busy_any}, 32'h0);
        check("reset_iss_ready", {31'b0, iss_ready}, 32'h1);

        for (int v = 0; v < 10; v++) begin
            ra1 = vecs[v].ra1; ra2 = vecs[v].ra2;
            we0 = vecs[v].we0; wa0 = vecs[v].wa0; wd0 = vecs[v].wd0;
            we1 = vecs[v].we1; wa1 = vecs[v].wa1; wd1 = vecs[v].wd1;
            #1;
            check($sformatf("vec%0d_rd1", v), rd1, vecs[v].exp_rd1);
            check($sformatf("vec%0d_rd2", v), rd2, vecs[v].exp_rd2);
            tick();
        end
        clear_inputs();

        // RAW against a multi-cycle producer on x7.
        issue(5'd0, 5'd0, 5'd7);
        #1 check("raw_issue_rd7_ready", {31'b0, iss_ready}, 32'h1);
        tick();
        issue(5'd7, 5'd0, 5'd0);
        #1;
        check("raw_busy_any", {31'b0, busy_any}, 32'h1);
        check("raw_stall", {31'b0, iss_ready}, 32'h0);
        tick();
        check("raw_stall_hold", {31'b0, iss_ready}, 32'h0);
        we0 = 1; wa0 = 5'd7; wd0 = 32'hABCD; ra1 = 5'd7;
        #1;
        check("raw_wb_ready", {31'b0, iss_ready}, 32'h1);
        check("raw_wb_bypass", rd1, 32'hABCD);
        tick();
        clear_inputs();
        #1;
        check("raw_busy_cleared", {31'b0, busy_any}, 32'h0);
        check("raw_stored", rd1, 32'hABCD);

        // WAW on x9.
        issue(5'd0, 5'd0, 5'd9);
        tick();
        #1 check("waw_stall", {31'b0, iss_ready}, 32'h0);
        tick();
        check("waw_stall_hold", {31'b0, iss_ready}, 32'h0);
        we1 = 1; wa1 = 5'd9; wd1 = 32'h99;
        #1 check("waw_wb_ready", {31'b0, iss_ready}, 32'h1);
        tick();
        clear_inputs();
        issue(5'd9, 5'd0, 5'd0);
        #1;
        check("waw_busy_kept", {31'b0, busy_any}, 32'h1);
        check("waw_new_owner_stall", {31'b0, iss_ready}, 32'h0);
        iss_valid = 0;
        we0 = 1; wa0 = 5'd9; wd0 = 32'h9;
        tick();
        clear_inputs();
        #1 check("waw_drained", {31'b0, busy_any}, 32'h0);

        // Accept-set and write-back-clear of x4 in the same cycle: set wins.
        issue(5'd0, 5'd0, 5'd4);
        tick();
        we1 = 1; wa1 = 5'd4; wd1 = 32'h44;
        #1 check("setclr_ready", {31'b0, iss_ready}, 32'h1);
        tick();
        clear_inputs();
        issue(5'd0, 5'd4, 5'd0);
        #1;
        check("setclr_busy_any", {31'b0, busy_any}, 32'h1);
        check("setclr_rs2_stall", {31'b0, iss_ready}, 32'h0);
        clear_inputs();
        we0 = 1; wa0 = 5'd4; wd0 = 32'h45;
        tick();
        clear_inputs();
        #1 check("setclr_drained", {31'b0, busy_any}, 32'h0);

        // Issue with no destination never marks anything busy.
        issue(5'd0, 5'd0, 5'd0);
        #1 check("rd0_ready", {31'b0, iss_ready}, 32'h1);
        tick();
        clear_inputs();
        #1 check("rd0_no_busy", {31'b0, busy_any}, 32'h0);

        // Reset drops outstanding busy bits and storage.
        issue(5'd0, 5'd0, 5'd2);
        tick();
        issue(5'd0, 5'd0, 5'd3);
        tick();
        issue(5'd2, 5'd3, 5'd0);
        #1;
        check("pre_rst_busy_any", {31'b0, busy_any}, 32'h1);
        check("pre_rst_stall", {31'b0, iss_ready}, 32'h0);
        iss_valid = 0;
        rst = 1;
        tick();
        rst = 0;
        ra1 = 5'd10; ra2 = 5'd7;
        #1;
        check("post_rst_busy_any", {31'b0, busy_any}, 32'h0);
        check("post_rst_ready", {31'b0, iss_ready}, 32'h1);
        check("post_rst_rd1", rd1, 32'h0);
        check("post_rst_rd2", rd2, 32'h0);

        // A late write-back after reset is an ordinary write.
        we0 = 1; wa0 = 5'd2; wd0 = 32'h2222;
        tick();
        clear_inputs();
        ra1 = 5'd2;
        #1;
        check("late_wb_stored", rd1, 32'h2222);
        check("late_wb_no_busy", {31'b0, busy_any}, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_regfile_sb

`default_nettype wire
